// File: rtl/and_arbiter_amisha_pkg.sv
// and_arbiter_amisha_pkg: shared defaults and FSM encoding for the AND arbiter
package and_arbiter_amisha_pkg;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESULT = 2'd2} state_t;
endpackage

// File: rtl/and_arbiter_amisha_rr_pick.sv
// rr_pick_amisha: round-robin pick of the first request at or above the pointer
module rr_pick_amisha
    import and_arbiter_amisha_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx
);
    logic [IW-1:0] w_try;
    // scan downward from the farthest offset so the nearest set bit to the pointer wins last
    always_comb begin
        w_try = '0;
        o_idx = i_ptr;
        o_onehot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_try = i_ptr + IW'(k);
            o_idx = i_req[w_try] ? w_try : o_idx;
        end
        if (|i_req) o_onehot[o_idx] = 1'b1;
    end
endmodule

// File: rtl/and_arbiter_amisha.sv
// and_arbiter_amisha: round-robin shared 3-input AND unit with ack handshake
module and_arbiter_amisha
    import and_arbiter_amisha_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic [N_REQ-1:0] req_amisha,
    input  logic [N_REQ-1:0] opa_amisha,
    input  logic [N_REQ-1:0] opb_amisha,
    input  logic [N_REQ-1:0] opc_amisha,
    input  logic             ack_amisha,
    output logic [N_REQ-1:0] gnt_amisha,
    output logic             y_amisha,
    output logic [IW-1:0]    id_amisha,
    output logic             valid_amisha,
    output logic             busy_amisha,
    output logic [CNT_W-1:0] ops_amisha
);
    state_t           r_state, w_next;
    logic [IW-1:0]    r_ptr, r_id, w_idx;
    logic [N_REQ-1:0] r_gnt, w_onehot;
    logic             r_a, r_b, r_c, r_y, r_valid;
    logic [CNT_W-1:0] r_ops;

    rr_pick_amisha #(.N_REQ(N_REQ)) u_pick (
        .i_req(req_amisha),
        .i_ptr(r_ptr),
        .o_onehot(w_onehot),
        .o_idx(w_idx)
    );

    // state register
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next-state: capture on any request, one CALC cycle, hold RESULT until ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |req_amisha ? CALC : IDLE;
            CALC:    w_next = RESULT;
            RESULT:  w_next = ack_amisha ? IDLE : RESULT;
            default: w_next = IDLE;
        endcase
    end

    // datapath: operand capture, registered AND, result handshake and op counter
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            r_ptr <= '0;
            r_id <= '0;
            r_gnt <= '0;
            r_a <= 1'b0;
            r_b <= 1'b0;
            r_c <= 1'b0;
            r_y <= 1'b0;
            r_valid <= 1'b0;
            r_ops <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gnt <= w_onehot;
                    if (|req_amisha) begin
                        r_id <= w_idx;
                        r_a <= opa_amisha[w_idx];
                        r_b <= opb_amisha[w_idx];
                        r_c <= opc_amisha[w_idx];
                    end
                end
                CALC: begin
                    r_gnt <= '0;
                    r_y <= r_a & r_b & r_c;
                    r_valid <= 1'b1;
                end
                RESULT: begin
                    if (ack_amisha) begin
                        r_valid <= 1'b0;
                        r_ptr <= r_id + IW'(1);
                        r_ops <= r_ops + CNT_W'(1);
                    end
                end
                default: r_gnt <= '0;
            endcase
        end
    end

    assign gnt_amisha = r_gnt;
    assign y_amisha = r_y;
    assign id_amisha = r_id;
    assign valid_amisha = r_valid;
    assign busy_amisha = (r_state != IDLE);
    assign ops_amisha = r_ops;
endmodule

// File: tb/tb_and_arbiter_amisha.sv
// tb_and_arbiter_amisha: directed self-checking bench for the AND arbiter
module tb_and_arbiter_amisha;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, opa, opb, opc, gnt;
    logic       ack, y, valid, busy;
    logic [1:0] id;
    logic [7:0] ops;
    int         checks = 0;
    int         failures = 0;
    logic [3:0] rr_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic       rr_y [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    and_arbiter_amisha dut (
        .clk_amisha(clk),
        .reset_amisha(rst),
        .req_amisha(req),
        .opa_amisha(opa),
        .opb_amisha(opb),
        .opc_amisha(opc),
        .ack_amisha(ack),
        .gnt_amisha(gnt),
        .y_amisha(y),
        .id_amisha(id),
        .valid_amisha(valid),
        .busy_amisha(busy),
        .ops_amisha(ops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 0);
        chk({tag, "_y"}, 32'(y), 0);
        chk({tag, "_id"}, 32'(id), 0);
        chk({tag, "_valid"}, 32'(valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ops"}, 32'(ops), 0);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        opa = '0;
        opb = '0;
        opc = '0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        req = 4'b0100;
        opa = 4'b0100;
        opb = 4'b0100;
        opc = 4'b0100;
        step();
        chk("single_gnt", 32'(gnt), 32'b0100);
        chk("single_id_at_gnt", 32'(id), 2);
        chk("single_valid_early", 32'(valid), 0);
        chk("single_busy", 32'(busy), 1);
        req = '0;
        opa = '0;
        step();
        chk("single_gnt_off", 32'(gnt), 0);
        chk("single_valid", 32'(valid), 1);
        chk("single_y", 32'(y), 1);
        chk("single_id", 32'(id), 2);
        ack = 1'b1;
        step();
        chk("single_valid_clr", 32'(valid), 0);
        chk("single_ops", 32'(ops), 1);
        chk("single_busy_clr", 32'(busy), 0);
        ack = 1'b0;
        req = 4'b0010;
        opa = 4'b0010;
        opb = 4'b0000;
        opc = 4'b0010;
        step();
        chk("zero_gnt", 32'(gnt), 32'b0010);
        req = '0;
        opa = 4'b1111;
        opb = 4'b1111;
        opc = 4'b1111;
        step();
        chk("zero_y", 32'(y), 0);
        chk("zero_id", 32'(id), 1);
        chk("zero_valid", 32'(valid), 1);
        for (int n = 0; n < 10; n++) begin
            step();
            chk("hold_valid", 32'(valid), 1);
            chk("hold_y", 32'(y), 0);
            chk("hold_id", 32'(id), 1);
            chk("hold_ops", 32'(ops), 1);
        end
        ack = 1'b1;
        step();
        chk("hold_valid_clr", 32'(valid), 0);
        chk("hold_ops_inc", 32'(ops), 2);
        for (int n = 0; n < 3; n++) begin
            step();
            chk("idle_ack_ops", 32'(ops), 2);
            chk("idle_ack_valid", 32'(valid), 0);
            chk("idle_ack_busy", 32'(busy), 0);
            chk("idle_ack_gnt", 32'(gnt), 0);
            chk("idle_ack_id", 32'(id), 1);
        end
        ack = 1'b0;
        req = 4'b0100;
        step();
        chk("midrst_gnt", 32'(gnt), 32'b0100);
        req = '0;
        step();
        step();
        chk("midrst_valid_pre", 32'(valid), 1);
        chk("midrst_y_pre", 32'(y), 1);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        step();
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        chk("post_rst_ops", 32'(ops), 0);
        req = '0;
        step();
        ack = 1'b1;
        step();
        chk("post_rst_ops_inc", 32'(ops), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        opa = 4'b1111;
        opb = 4'b0101;
        opc = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(rr_gnt[n]));
            chk("rr_busy", 32'(busy), 1);
            step();
            chk("rr_valid", 32'(valid), 1);
            chk("rr_y", 32'(y), 32'(rr_y[n]));
            chk("rr_gnt_calc_off", 32'(gnt), 0);
            step();
            chk("rr_valid_clr", 32'(valid), 0);
            chk("rr_gnt_res_off", 32'(gnt), 0);
        end
        chk("rr_ops", 32'(ops), 5);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1111;
        for (int n = 0; n < 256; n++) begin
            repeat (3) step();
            if (n == 254) chk("wrap_ops_max", 32'(ops), 255);
        end
        chk("wrap_ops_zero", 32'(ops), 0);
        req = '0;
        ack = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
